// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32 subset CPU.
// Owns the PC, drives registered strobes, and halts on EBREAK, illegal codes or data-RAM timeouts.
module cpu_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ready,
  input  logic [11:0] execution,
  input  logic [31:0] branch_address,
  input  logic [31:0] jump_address,
  input  logic        alu_zero,
  input  logic        dmem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        dec_en,
  output logic        alu_en,
  output logic [11:0] alu_op,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] link_addr,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] retired
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam int OP_LW   = 0;
  localparam int OP_SW   = 2;
  localparam int OP_BEQ  = 3;
  localparam int OP_JAL  = 9;
  localparam int OP_HALT = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  function automatic logic f_is_onehot12(input logic [11:0] code);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 12; i++) begin
      cnt = cnt + {3'd0, code[i]};
    end
    return (cnt == 4'd1);
  endfunction

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_link;
  logic [31:0]   r_retired;
  logic          r_halted;
  logic [1:0]    r_fault;
  logic [11:0]   r_alu_op;
  logic [1:0]    r_wb_sel;
  logic [CW-1:0] r_wait;
  logic          r_imem_req;
  logic          r_dec_en;
  logic          r_alu_en;
  logic          r_dmem_rd;
  logic          r_dmem_wr;
  logic          r_reg_we;

  state_t        w_state_nx;
  logic [31:0]   w_pc_nx;
  logic [31:0]   w_link_nx;
  logic [31:0]   w_retired_nx;
  logic          w_halted_nx;
  logic [1:0]    w_fault_nx;
  logic [11:0]   w_op_nx;
  logic [1:0]    w_wb_sel_nx;
  logic [CW-1:0] w_wait_nx;
  logic          w_imem_req_nx;
  logic          w_dec_en_nx;
  logic          w_alu_en_nx;
  logic          w_dmem_rd_nx;
  logic          w_dmem_wr_nx;
  logic          w_reg_we_nx;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_retired_inc;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_retired_inc = r_retired + 32'd1;

  // Next-state, PC/bookkeeping updates and next-cycle strobe decode.
  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_link_nx    = r_link;
    w_retired_nx = r_retired;
    w_halted_nx  = r_halted;
    w_fault_nx   = r_fault;
    w_op_nx      = r_alu_op;
    w_wb_sel_nx  = r_wb_sel;
    w_wait_nx    = r_wait;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_FETCH;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ready) begin
          w_state_nx = S_DECODE;
          w_link_nx  = w_pc_plus4;
        end else begin
          w_state_nx = S_FETCH;
        end
      end
      S_DECODE: begin
        w_state_nx = S_EXEC;
      end
      S_EXEC: begin
        w_op_nx = execution;
        if (!f_is_onehot12(execution)) begin
          w_halted_nx = 1'b1;
          w_fault_nx  = 2'd1;
          w_state_nx  = S_HALT;
        end else if (execution[OP_HALT]) begin
          w_halted_nx  = 1'b1;
          w_fault_nx   = 2'd0;
          w_retired_nx = w_retired_inc;
          w_state_nx   = S_HALT;
        end else if (execution[OP_LW] || execution[OP_SW]) begin
          w_wait_nx  = '0;
          w_state_nx = S_MEM;
        end else if (execution[OP_BEQ]) begin
          // alu_zero reflects rs1-rs2 while the decoder code is presented in EXEC.
          w_pc_nx      = alu_zero ? (r_pc + branch_address) : w_pc_plus4;
          w_retired_nx = w_retired_inc;
          w_state_nx   = S_FETCH;
        end else if (execution[OP_JAL]) begin
          w_pc_nx     = r_pc + jump_address;
          w_wb_sel_nx = 2'd2;
          w_state_nx  = S_WB;
        end else begin
          w_wb_sel_nx = 2'd0;
          w_state_nx  = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (r_alu_op[OP_LW]) begin
            w_wb_sel_nx = 2'd1;
            w_state_nx  = S_WB;
          end else begin
            w_pc_nx      = w_pc_plus4;
            w_retired_nx = w_retired_inc;
            w_state_nx   = S_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_halted_nx = 1'b1;
          w_fault_nx  = 2'd2;
          w_state_nx  = S_HALT;
        end else begin
          w_wait_nx = r_wait + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_WB: begin
        if (r_alu_op[OP_JAL]) begin
          w_pc_nx = r_pc;
        end else begin
          w_pc_nx = w_pc_plus4;
        end
        w_retired_nx = w_retired_inc;
        w_state_nx   = S_FETCH;
      end
      S_HALT: begin
        w_state_nx = S_HALT;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Strobes are registered alongside the state so each one lines up with its state.
    w_imem_req_nx = (w_state_nx == S_FETCH);
    w_dec_en_nx   = (w_state_nx == S_DECODE);
    w_alu_en_nx   = (r_state == S_EXEC) && (w_state_nx != S_HALT);
    w_dmem_rd_nx  = (w_state_nx == S_MEM) && w_op_nx[OP_LW];
    w_dmem_wr_nx  = (w_state_nx == S_MEM) && w_op_nx[OP_SW];
    w_reg_we_nx   = (w_state_nx == S_WB);
  end

  // State, PC, bookkeeping and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_link     <= RESET_PC + 32'd4;
      r_retired  <= 32'd0;
      r_halted   <= 1'b0;
      r_fault    <= 2'd0;
      r_alu_op   <= 12'd0;
      r_wb_sel   <= 2'd0;
      r_wait     <= '0;
      r_imem_req <= 1'b0;
      r_dec_en   <= 1'b0;
      r_alu_en   <= 1'b0;
      r_dmem_rd  <= 1'b0;
      r_dmem_wr  <= 1'b0;
      r_reg_we   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_link     <= w_link_nx;
      r_retired  <= w_retired_nx;
      r_halted   <= w_halted_nx;
      r_fault    <= w_fault_nx;
      r_alu_op   <= w_op_nx;
      r_wb_sel   <= w_wb_sel_nx;
      r_wait     <= w_wait_nx;
      r_imem_req <= w_imem_req_nx;
      r_dec_en   <= w_dec_en_nx;
      r_alu_en   <= w_alu_en_nx;
      r_dmem_rd  <= w_dmem_rd_nx;
      r_dmem_wr  <= w_dmem_wr_nx;
      r_reg_we   <= w_reg_we_nx;
    end
  end

  assign pc        = r_pc;
  assign imem_req  = r_imem_req;
  assign dec_en    = r_dec_en;
  assign alu_en    = r_alu_en;
  assign alu_op    = r_alu_op;
  assign dmem_rd   = r_dmem_rd;
  assign dmem_wr   = r_dmem_wr;
  assign reg_we    = r_reg_we;
  assign wb_sel    = r_wb_sel;
  assign link_addr = r_link;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl: ALU, LW/SW, BEQ, JAL, illegal code,
// EBREAK, data-RAM timeout and asynchronous reset mid-access.
module tb_cpu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ready = 1'b0;
  logic [11:0] execution = 12'd0;
  logic [31:0] branch_address = 32'd0;
  logic [31:0] jump_address = 32'd0;
  logic        alu_zero = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [31:0] pc;
  logic        imem_req;
  logic        dec_en;
  logic        alu_en;
  logic [11:0] alu_op;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [31:0] link_addr;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retired;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt;
  int wr_cnt;
  logic we_seen;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
    .execution(execution), .branch_address(branch_address), .jump_address(jump_address),
    .alu_zero(alu_zero), .dmem_ready(dmem_ready), .pc(pc), .imem_req(imem_req),
    .dec_en(dec_en), .alu_en(alu_en), .alu_op(alu_op), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .reg_we(reg_we), .wb_sel(wb_sel), .link_addr(link_addr),
    .halted(halted), .fault(fault), .retired(retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic run_beq(input logic [31:0] off, input logic zero);
    execution = 12'h008; branch_address = off; alu_zero = zero;
    tick(); we_seen = we_seen | reg_we;
    tick(); we_seen = we_seen | reg_we;
    tick(); we_seen = we_seen | reg_we;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'd0);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk1("rst_imem_req", imem_req, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("idle_no_req", imem_req, 1'b0);

    // ADD at pc 0
    start = 1'b1; imem_ready = 1'b1; execution = 12'h010;
    tick(); chk1("add_fetch_req", imem_req, 1'b1);
    tick(); chk1("add_dec_en", dec_en, 1'b1); chk("add_link", link_addr, 32'h4);
    tick(); chk1("add_dec_once", dec_en, 1'b0); chk1("add_no_we_exec", reg_we, 1'b0);
    tick();
    chk1("add_reg_we", reg_we, 1'b1);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    chk1("add_alu_en", alu_en, 1'b1);
    chk("add_alu_op", 32'(alu_op), 32'h010);
    chk("add_pc_in_wb", pc, 32'h0);
    tick();
    chk("add_pc", pc, 32'h4); chk("add_retired", retired, 32'd1);
    chk1("add_we_off", reg_we, 1'b0); chk1("add_refetch", imem_req, 1'b1);

    // LW at pc 4, three wait cycles
    execution = 12'h001; dmem_ready = 1'b0;
    tick(); tick();
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dmem_rd) rd_cnt++;
    end
    dmem_ready = 1'b1;
    tick();
    chk("lw_rd_cycles", rd_cnt, 32'd4);
    chk1("lw_rd_drop", dmem_rd, 1'b0);
    chk1("lw_reg_we", reg_we, 1'b1);
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    dmem_ready = 1'b0;
    tick();
    chk("lw_pc", pc, 32'h8); chk("lw_retired", retired, 32'd2);

    // SW at pc 8, ready on first MEM cycle
    execution = 12'h004;
    tick(); tick(); tick();
    chk1("sw_wr", dmem_wr, 1'b1); chk1("sw_no_rd", dmem_rd, 1'b0);
    dmem_ready = 1'b1;
    tick();
    chk1("sw_wr_drop", dmem_wr, 1'b0); chk1("sw_no_we", reg_we, 1'b0);
    chk("sw_pc", pc, 32'hC); chk("sw_retired", retired, 32'd3);
    dmem_ready = 1'b0;

    // XOR at pc 0xC with one instruction-fetch stall
    imem_ready = 1'b0; execution = 12'h080;
    tick(); chk1("stall_req", imem_req, 1'b1); chk1("stall_no_dec", dec_en, 1'b0);
    imem_ready = 1'b1;
    tick(); tick(); tick();
    chk1("xor_reg_we", reg_we, 1'b1);
    tick();
    chk("xor_pc", pc, 32'h10); chk("xor_retired", retired, 32'd4);

    // BEQ chain: 0x10 taken -8 -> 0x08, taken +8 -> 0x10, not taken -> 0x14, taken +0xC -> 0x20
    we_seen = 1'b0;
    run_beq(32'hFFFF_FFF8, 1'b1);
    chk("beq_taken_pc", pc, 32'h08); chk("beq_retired", retired, 32'd5);
    chk1("beq_alu_en", alu_en, 1'b1);
    run_beq(32'h0000_0008, 1'b1);
    chk("beq_taken2_pc", pc, 32'h10);
    run_beq(32'hFFFF_FFF8, 1'b0);
    chk("beq_nt_pc", pc, 32'h14); chk("beq_nt_retired", retired, 32'd7);
    run_beq(32'h0000_000C, 1'b1);
    chk("beq_to_jal_pc", pc, 32'h20);
    chk1("beq_no_we", we_seen, 1'b0);

    // JAL at 0x20, offset 0x100
    execution = 12'h200; jump_address = 32'h0000_0100;
    tick(); chk("jal_link_dec", link_addr, 32'h24);
    tick(); tick();
    chk("jal_pc_wb", pc, 32'h120); chk("jal_wb_sel", 32'(wb_sel), 32'd2);
    chk("jal_link_wb", link_addr, 32'h24); chk1("jal_reg_we", reg_we, 1'b1);
    tick();
    chk("jal_pc", pc, 32'h120); chk1("jal_we_off", reg_we, 1'b0);
    chk("jal_retired", retired, 32'd9);

    // Illegal code 0x003 at 0x120
    execution = 12'h003;
    tick(); tick(); tick();
    chk1("ill_halted", halted, 1'b1); chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_retired", retired, 32'd9); chk1("ill_no_alu_en", alu_en, 1'b0);
    chk("ill_alu_op", 32'(alu_op), 32'h003);
    repeat (3) tick();
    chk1("ill_absorb_req", imem_req, 1'b0); chk("ill_absorb_pc", pc, 32'h120);

    // Asynchronous reset out of HALT
    rst_n = 1'b0; #2;
    chk("rst2_pc", pc, 32'h0); chk("rst2_retired", retired, 32'd0);
    chk1("rst2_halted", halted, 1'b0); chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_wb_sel", 32'(wb_sel), 32'd0); chk("rst2_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;

    // EBREAK, start held high afterwards
    execution = 12'h400;
    tick(); tick(); tick(); tick();
    chk1("brk_halted", halted, 1'b1); chk("brk_fault", 32'(fault), 32'd0);
    chk("brk_retired", retired, 32'd1); chk("brk_pc", pc, 32'h0);
    repeat (3) tick();
    chk1("brk_start_ignored", imem_req, 1'b0); chk("brk_retired_hold", retired, 32'd1);

    // SW with dmem_ready stuck low -> timeout after 16 MEM cycles
    rst_n = 1'b0; #2; rst_n = 1'b1;
    execution = 12'h004; dmem_ready = 1'b0;
    tick(); tick(); tick();
    wr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (dmem_wr) wr_cnt++;
    end
    chk("to_wr_cycles", wr_cnt, 32'd16); chk1("to_not_yet", halted, 1'b0);
    tick();
    chk1("to_wr_drop", dmem_wr, 1'b0); chk1("to_halted", halted, 1'b1);
    chk("to_fault", 32'(fault), 32'd2); chk("to_retired", retired, 32'd0);

    // Reset pulse in the middle of an LW access
    rst_n = 1'b0; #2; rst_n = 1'b1;
    execution = 12'h001;
    repeat (5) tick();
    chk1("mid_rd_high", dmem_rd, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk1("mid_rd_async_drop", dmem_rd, 1'b0); chk("mid_pc", pc, 32'h0);
    start = 1'b0; #2; rst_n = 1'b1;
    tick(); chk1("mid_idle", imem_req, 1'b0);
    start = 1'b1;
    tick(); chk1("mid_restart", imem_req, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the RV32 subset CPU.
- Owns the PC and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Pulses the instruction decoder's dec_en and consumes its 12-bit one-hot execution code.
- Generates ALU, data-RAM and register-file strobes, handles BEQ/JAL redirection, and stops on EBREAK or on a fault.

Parameters:
RESET_PC, 32'h00000000, PC value loaded at reset
MEM_TIMEOUT, 16, max cycles in a memory wait state before a fault halt (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; leave IDLE when high
imem_ready  in  1  instruction RAM has inst valid this cycle
execution  in  12  one-hot decoder code: b0 LW, b1 SLLI, b2 SW, b3 BEQ, b4 ADD, b5 SUB, b6 SLL, b7 XOR, b8 OR, b9 JAL, b10 HALT, b11 AND
branch_address  in  32  signed byte offset from decoder (BEQ)
jump_address  in  32  signed byte offset from decoder (JAL)
alu_zero  in  1  ALU result == 0 (rs1-rs2 for BEQ)
dmem_ready  in  1  data RAM access complete
pc  out  32  current instruction address
imem_req  out  1  instruction fetch request
dec_en  out  1  one-cycle decoder latch pulse
alu_en  out  1  ALU operate strobe
alu_op  out  12  copy of latched execution code driven to ALU
dmem_rd  out  1  data RAM read (LW)
dmem_wr  out  1  data RAM write (SW)
reg_we  out  1  register-file write strobe
wb_sel  out  2  0 ALU result, 1 dmem data, 2 link (pc+4)
link_addr  out  32  pc+4 of current instruction
halted  out  1  sticky, CPU stopped
fault  out  2  0 none, 1 illegal code, 2 dmem timeout
retired  out  32  count of completed instructions, wraps

Behaviour:
- Reset (async, any state): state=IDLE; pc=RESET_PC; retired=0; halted=0; fault=0; all strobes 0; alu_op=0; wb_sel=0.
- All strobes are registered and decoded from the state. Each is high for exactly the cycles listed below.
- IDLE: strobes 0. If start=1, go to FETCH.
- FETCH: imem_req=1. Stays in FETCH while imem_ready=0. When imem_ready=1, go to DECODE.
- DECODE: dec_en=1 for exactly one cycle, then go to EXEC. The decoder output is valid from the first EXEC cycle.
- EXEC: latch execution into alu_op. Check execution:
  - Zero or not one-hot: halted=1, fault=1, go to HALT.
  - b10 HALT: halted=1, fault=0, go to HALT. retired increments for EBREAK.
  - Otherwise alu_en=1 for one cycle, then dispatch:
    - LW or SW: go to MEM.
    - BEQ: if alu_zero=1, pc <= pc + branch_address; else pc <= pc+4. retired+1. Go to FETCH. No WB.
    - JAL: pc <= pc + jump_address; wb_sel=2. Go to WB.
    - ALU ops (SLLI, ADD, SUB, SLL, XOR, OR, AND): wb_sel=0. Go to WB.
- MEM:
  - LW: dmem_rd=1. SW: dmem_wr=1.
  - Strobe held until dmem_ready=1.
  - On ready, LW sets wb_sel=1 and goes to WB. SW does pc <= pc+4, retired+1, goes to FETCH.
  - A wait counter resets on MEM entry. If MEM_TIMEOUT cycles pass without dmem_ready: halted=1, fault=2, strobes drop, go to HALT.
- WB: reg_we=1 for one cycle; retired+1. pc <= pc+4, except for JAL, where pc was already redirected in EXEC. Go to FETCH.
- HALT: absorbing, all strobes 0. Only rst_n leaves it. start is ignored.
- link_addr = pc+4, computed from the pc captured at FETCH. It is stable through WB even after the JAL redirect.
- Arithmetic: all PC math is 32-bit modulo 2^32 (wraps). retired wraps 0xFFFFFFFF -> 0.
- start deasserted mid-instruction has no effect. The sequencer returns to IDLE only via reset.
- Reset mid-MEM: dmem_rd and dmem_wr drop asynchronously. No write is completed by the sequencer.

Test Plan:
- ADD at RESET_PC=0, imem_ready=1: FETCH, DECODE, EXEC, WB. dec_en pulses once. reg_we in cycle 4 with wb_sel=0. pc=4, retired=1.
- LW with dmem_ready after 3 wait cycles: dmem_rd high for 4 cycles, then WB with wb_sel=1. pc=8. SW variant has no reg_we.
- BEQ at pc=0x10, branch_address=0xFFFFFFF8: alu_zero=1 gives pc=0x08; alu_zero=0 gives pc=0x14. reg_we never asserts.
- JAL at pc=0x20, jump_address=0x100: pc=0x120, wb_sel=2, link_addr=0x24, reg_we one cycle.
- execution=12'b000000000011: halted=1, fault=1, retired unchanged. Later EBREAK run: halted=1, fault=0, start ignored.
- SW with dmem_ready stuck 0 and MEM_TIMEOUT=16: fault=2 after 16 MEM cycles, dmem_wr drops. Then rst_n pulse mid-run: pc=RESET_PC, state IDLE.
